// File: rtl/tile_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tile_io_pkg
//  Description : Shared widths, fill byte and FSM state codes for the tile
//                I/O responder.
//  Revision    : 1.0
// ============================================================================
package tile_io_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    localparam logic [DATA_W-1:0] FILL_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } tile_io_state_e;

    // Plain-vector state codes used by the FSM register.
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_done   = 2'd2;

endpackage : tile_io_pkg
`default_nettype wire

// File: rtl/tile_io_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tile_io_sync
//  Description : Multi-flop synchronizer for asynchronous bus strobes; resets
//                to the inactive level given by RESET_VAL.
//  Revision    : 1.0
// ============================================================================
module tile_io_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_chain <= {STAGES{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule : tile_io_sync
`default_nettype wire

// File: rtl/tile_io_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tile_io_responder
//  Description : Dock-bus slave that turns a synchronized I/O strobe into a
//                local register request, holding the CPU with wait_n until the
//                register side acknowledges. Define TILE_IO_TIMEOUT_EN to add
//                a forced-completion timeout.
//  Revision    : 1.0
// ============================================================================
module tile_io_responder
    import tile_io_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iorq_n,
    input  logic              cs_n,
    input  logic              io_r_w_,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    output logic              d_oe_n,
    output logic              wait_n,
    output logic              reg_req,
    output logic              reg_we,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata,
    input  logic              reg_ack,
    output logic              timeout_p
);

    logic              w_iorq_s;
    logic              w_cs_s;
    logic              w_sel;
    logic              w_sel_rise;
    logic              w_expired;
    logic              r_sel_d;
    logic [1:0]        r_state;
    logic              r_reg_req;
    logic              r_reg_we;
    logic [ADDR_W-1:0] r_reg_addr;
    logic [DATA_W-1:0] r_reg_wdata;
    logic [DATA_W-1:0] r_d_out;
    logic              r_d_oe_n;
    logic              r_wait_n;

    tile_io_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_iorq (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (iorq_n),
        .q     (w_iorq_s)
    );

    tile_io_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cs_n),
        .q     (w_cs_s)
    );

    assign w_sel      = ~w_iorq_s & ~w_cs_s;
    // Edge-qualified so a strobe still held after DONE cannot start a new cycle.
    assign w_sel_rise = w_sel & ~r_sel_d;

`ifdef TILE_IO_TIMEOUT_EN
    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;
    logic       r_timeout_p;

    assign w_expired = (r_cnt == c_timeout_last);
    assign timeout_p = r_timeout_p;

    // Counter only advances on live, unacknowledged ACCESS cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= 8'd0;
            r_timeout_p <= 1'b0;
        end else begin
            r_timeout_p <= 1'b0;
            if (r_state != c_st_access) begin
                r_cnt <= 8'd0;
            end else if (w_sel && !reg_ack) begin
                if (w_expired) begin
                    r_timeout_p <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end
`else
    logic [7:0] w_unused_timeout;

    assign w_unused_timeout = 8'(TIMEOUT);
    assign w_expired        = 1'b0;
    assign timeout_p        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel_d     <= 1'b0;
            r_state     <= c_st_idle;
            r_reg_req   <= 1'b0;
            r_reg_we    <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_d_out     <= FILL_BYTE;
            r_d_oe_n    <= 1'b1;
            r_wait_n    <= 1'b1;
        end else begin
            r_sel_d <= w_sel;
            case (r_state)
                c_st_idle: begin
                    if (w_sel_rise) begin
                        r_reg_addr  <= addr;
                        r_reg_we    <= ~io_r_w_;
                        r_reg_wdata <= d_in;
                        r_reg_req   <= 1'b1;
                        r_wait_n    <= 1'b0;
                        r_state     <= c_st_access;
                    end
                end
                c_st_access: begin
                    // Abort outranks ack so data is never driven to a departed CPU.
                    if (!w_sel) begin
                        r_reg_req <= 1'b0;
                        r_wait_n  <= 1'b1;
                        r_state   <= c_st_idle;
                    end else if (reg_ack) begin
                        if (!r_reg_we) begin
                            r_d_out <= reg_rdata;
                        end
                        r_d_oe_n  <= r_reg_we;
                        r_reg_req <= 1'b0;
                        r_wait_n  <= 1'b1;
                        r_state   <= c_st_done;
                    end else if (w_expired) begin
                        r_d_out   <= FILL_BYTE;
                        r_d_oe_n  <= r_reg_we;
                        r_reg_req <= 1'b0;
                        r_wait_n  <= 1'b1;
                        r_state   <= c_st_done;
                    end
                end
                c_st_done: begin
                    if (!w_sel) begin
                        r_d_oe_n <= 1'b1;
                        r_state  <= c_st_idle;
                    end
                end
                default: begin
                    r_reg_req <= 1'b0;
                    r_d_oe_n  <= 1'b1;
                    r_wait_n  <= 1'b1;
                    r_state   <= c_st_idle;
                end
            endcase
        end
    end

    assign d_out     = r_d_out;
    assign d_oe_n    = r_d_oe_n;
    assign wait_n    = r_wait_n;
    assign reg_req   = r_reg_req;
    assign reg_we    = r_reg_we;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;

endmodule : tile_io_responder
`default_nettype wire

// File: tb/tb_tile_io_responder.sv
`default_nettype none
// Self-checking bench for tile_io_responder: transaction-level expectations
// derived from the bus protocol, randomized over direction, data and timing.
module tb_tile_io_responder;

    localparam int SYNC = 2;
    localparam int TMO  = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iorq_n = 1'b1;
    logic       cs_n = 1'b1;
    logic       io_r_w_ = 1'b1;
    logic [3:0] addr = 4'h0;
    logic [7:0] d_in = 8'h00;
    logic [7:0] d_out;
    logic       d_oe_n;
    logic       wait_n;
    logic       reg_req;
    logic       reg_we;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata = 8'h00;
    logic       reg_ack = 1'b0;
    logic       timeout_p;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] exp_dout = 8'hFF;

    tile_io_responder #(.SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iorq_n    (iorq_n),
        .cs_n      (cs_n),
        .io_r_w_   (io_r_w_),
        .addr      (addr),
        .d_in      (d_in),
        .d_out     (d_out),
        .d_oe_n    (d_oe_n),
        .wait_n    (wait_n),
        .reg_req   (reg_req),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack),
        .timeout_p (timeout_p)
    );

    always #5 clk = ~clk;

    // Assert the strobes and wait for the request; returns at the first
    // negedge showing reg_req, with bus inputs scrambled afterwards.
    task automatic start_access(input bit rd, input logic [3:0] a, input logic [7:0] wd);
        int lat;
        lat = 0;
        @(negedge clk);
        io_r_w_ = rd; addr = a; d_in = wd;
        iorq_n = 1'b0; cs_n = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (reg_req !== 1'b1 && lat < 20);
        n_checks++;
        if (lat != SYNC + 1) $display("FAIL req_latency: got %0d cycles want %0d", lat, SYNC + 1);
        else n_pass++;
        n_checks++;
        if ({reg_we, reg_addr, reg_wdata, wait_n, d_oe_n} !== {~rd, a, wd, 1'b0, 1'b1})
            $display("FAIL latch: got we=%b a=%h wd=%h wait_n=%b oe_n=%b want we=%b a=%h wd=%h wait_n=0 oe_n=1",
                     reg_we, reg_addr, reg_wdata, wait_n, d_oe_n, ~rd, a, wd);
        else n_pass++;
        io_r_w_ = ~rd; addr = ~a; d_in = ~wd;
    endtask

    task automatic release_bus(input bit rd);
        reg_ack = 1'b0;
        if (($urandom & 1) == 1) iorq_n = 1'b1; else cs_n = 1'b1;
        for (int k = 1; k <= SYNC; k++) begin
            @(negedge clk);
            n_checks++;
            if ({d_oe_n, wait_n, d_out} !== {~rd, 1'b1, exp_dout})
                $display("FAIL release_hold: got oe_n=%b wait_n=%b d_out=%h want oe_n=%b wait_n=1 d_out=%h",
                         d_oe_n, wait_n, d_out, ~rd, exp_dout);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if ({d_oe_n, wait_n, reg_req} !== 3'b110)
            $display("FAIL release_end: got oe_n=%b wait_n=%b req=%b want 1 1 0", d_oe_n, wait_n, reg_req);
        else n_pass++;
        iorq_n = 1'b1; cs_n = 1'b1;
    endtask

    // Hold off the ack for dly cycles of reg_req, then linger in DONE.
    task automatic finish_ack(input bit rd, input logic [3:0] a, input logic [7:0] wd,
                              input logic [7:0] rdat, input int dly, input int hold);
        for (int k = 1; k < dly; k++) begin
            @(negedge clk);
            n_checks++;
            if ({reg_req, wait_n, d_oe_n, timeout_p, reg_we, reg_addr, reg_wdata} !== {4'b1010, ~rd, a, wd})
                $display("FAIL access_hold: cycle %0d got req=%b wait_n=%b oe_n=%b to=%b a=%h wd=%h",
                         k, reg_req, wait_n, d_oe_n, timeout_p, reg_addr, reg_wdata);
            else n_pass++;
        end
        reg_rdata = rdat; reg_ack = 1'b1;
        @(negedge clk);
        reg_ack = 1'b0;
        if (rd) exp_dout = rdat;
        n_checks++;
        if ({wait_n, reg_req, d_oe_n, timeout_p, d_out} !== {1'b1, 1'b0, ~rd, 1'b0, exp_dout})
            $display("FAIL complete: got wait_n=%b req=%b oe_n=%b to=%b d_out=%h want 1 0 %b 0 %h",
                     wait_n, reg_req, d_oe_n, timeout_p, d_out, ~rd, exp_dout);
        else n_pass++;
        for (int k = 0; k < hold; k++) begin
            reg_ack = 1'($urandom); reg_rdata = 8'($urandom);
            @(negedge clk);
            n_checks++;
            if ({wait_n, reg_req, d_oe_n, d_out} !== {1'b1, 1'b0, ~rd, exp_dout})
                $display("FAIL done_hold: got wait_n=%b req=%b oe_n=%b d_out=%h want 1 0 %b %h",
                         wait_n, reg_req, d_oe_n, d_out, ~rd, exp_dout);
            else n_pass++;
        end
        release_bus(rd);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({reg_req, reg_we, reg_addr, reg_wdata, d_out, d_oe_n, wait_n, timeout_p} !== {2'b00, 4'h0, 8'h00, 8'hFF, 3'b110})
            $display("FAIL reset: got req=%b we=%b a=%h wd=%h d_out=%h oe_n=%b wait_n=%b to=%b",
                     reg_req, reg_we, reg_addr, reg_wdata, d_out, d_oe_n, wait_n, timeout_p);
        else n_pass++;
        rst_n = 1'b1;
        exp_dout = 8'hFF;
    endtask

    task automatic test_read;
        start_access(1'b1, 4'h3, 8'h11);
        finish_ack(1'b1, 4'h3, 8'h11, 8'hA5, 3, 2);
    endtask

    task automatic test_write;
        start_access(1'b0, 4'h7, 8'h3C);
        finish_ack(1'b0, 4'h7, 8'h3C, 8'h5A, 2, 2);
    endtask

    task automatic test_random;
        for (int t = 0; t < 12; t++) begin
            bit         rd;
            logic [3:0] a;
            logic [7:0] wd;
            rd = 1'($urandom); a = 4'($urandom); wd = 8'($urandom);
            start_access(rd, a, wd);
            finish_ack(rd, a, wd, 8'($urandom), int'($urandom_range(6, 1)), int'($urandom_range(3, 0)));
        end
    endtask

    task automatic test_back_to_back;
        start_access(1'b1, 4'hE, 8'h00);
        finish_ack(1'b1, 4'hE, 8'h00, 8'h81, 1, 0);
        start_access(1'b0, 4'h1, 8'hC3);
        finish_ack(1'b0, 4'h1, 8'hC3, 8'h7E, 1, 0);
    endtask

    task automatic test_abort;
        start_access(1'b1, 4'h9, 8'h00);
        @(negedge clk);
        cs_n = 1'b1;
        for (int k = 1; k <= SYNC; k++) begin
            @(negedge clk);
            n_checks++;
            if ({reg_req, wait_n, d_oe_n} !== 3'b101)
                $display("FAIL abort_sync: got req=%b wait_n=%b oe_n=%b want 1 0 1", reg_req, wait_n, d_oe_n);
            else n_pass++;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            reg_ack = (k == 1);
            n_checks++;
            if ({reg_req, wait_n, d_oe_n, d_out} !== {3'b011, exp_dout})
                $display("FAIL abort_idle: got req=%b wait_n=%b oe_n=%b d_out=%h want 0 1 1 %h",
                         reg_req, wait_n, d_oe_n, d_out, exp_dout);
            else n_pass++;
        end
        reg_ack = 1'b0; iorq_n = 1'b1;
    endtask

    task automatic test_stray_ack;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            reg_ack = 1'b1; reg_rdata = 8'($urandom);
            @(negedge clk);
            reg_ack = 1'b0;
            n_checks++;
            if ({reg_req, wait_n, d_oe_n, timeout_p, d_out} !== {4'b0110, exp_dout})
                $display("FAIL stray_ack: got req=%b wait_n=%b oe_n=%b to=%b d_out=%h want 0 1 1 0 %h",
                         reg_req, wait_n, d_oe_n, timeout_p, d_out, exp_dout);
            else n_pass++;
        end
    endtask

`ifdef TILE_IO_TIMEOUT_EN
    task automatic test_timeout;
        start_access(1'b1, 4'h5, 8'h00);
        for (int k = 1; k < TMO; k++) begin
            @(negedge clk);
            n_checks++;
            if ({reg_req, wait_n, timeout_p} !== 3'b100)
                $display("FAIL timeout_wait: cycle %0d got req=%b wait_n=%b to=%b", k, reg_req, wait_n, timeout_p);
            else n_pass++;
        end
        @(negedge clk);
        exp_dout = 8'hFF;
        n_checks++;
        if ({timeout_p, wait_n, reg_req, d_oe_n, d_out} !== {4'b1100, 8'hFF})
            $display("FAIL timeout_fire: got to=%b wait_n=%b req=%b oe_n=%b d_out=%h want 1 1 0 0 ff",
                     timeout_p, wait_n, reg_req, d_oe_n, d_out);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (timeout_p !== 1'b0) $display("FAIL timeout_pulse: got %b want 0", timeout_p);
        else n_pass++;
        release_bus(1'b1);
        start_access(1'b1, 4'h6, 8'h00);
        finish_ack(1'b1, 4'h6, 8'h00, 8'h4B, TMO, 1);
    endtask
`else
    task automatic test_no_timeout;
        start_access(1'b1, 4'h5, 8'h00);
        for (int k = 1; k < 3 * TMO; k++) begin
            @(negedge clk);
            n_checks++;
            if ({reg_req, wait_n, timeout_p} !== 3'b100)
                $display("FAIL no_timeout: cycle %0d got req=%b wait_n=%b to=%b", k, reg_req, wait_n, timeout_p);
            else n_pass++;
        end
        iorq_n = 1'b1;
        repeat (SYNC + 1) @(negedge clk);
        n_checks++;
        if ({reg_req, wait_n, d_oe_n, d_out} !== {3'b011, exp_dout})
            $display("FAIL no_timeout_abort: got req=%b wait_n=%b oe_n=%b d_out=%h", reg_req, wait_n, d_oe_n, d_out);
        else n_pass++;
        cs_n = 1'b1;
    endtask
`endif

    task automatic test_reset_in_done;
        start_access(1'b1, 4'hB, 8'h00);
        reg_rdata = 8'h96; reg_ack = 1'b1;
        @(negedge clk);
        reg_ack = 1'b0;
        rst_n = 1'b0; iorq_n = 1'b1; cs_n = 1'b1;
        @(negedge clk);
        exp_dout = 8'hFF;
        n_checks++;
        if ({d_oe_n, wait_n, reg_req, reg_we, reg_addr, reg_wdata, d_out} !== {4'b1100, 4'h0, 8'h00, 8'hFF})
            $display("FAIL reset_done: got oe_n=%b wait_n=%b req=%b we=%b a=%h wd=%h d_out=%h",
                     d_oe_n, wait_n, reg_req, reg_we, reg_addr, reg_wdata, d_out);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_reset_in_access;
        start_access(1'b1, 4'hD, 8'h00);
        rst_n = 1'b0; iorq_n = 1'b1; cs_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if ({reg_req, wait_n, d_oe_n, d_out} !== {3'b011, 8'hFF})
            $display("FAIL reset_access: got req=%b wait_n=%b oe_n=%b d_out=%h", reg_req, wait_n, d_oe_n, d_out);
        else n_pass++;
        reg_rdata = 8'h33; reg_ack = 1'b1;
        repeat (2) @(negedge clk);
        reg_ack = 1'b0;
        n_checks++;
        if ({reg_req, wait_n, d_oe_n, d_out} !== {3'b011, exp_dout})
            $display("FAIL late_ack: got req=%b wait_n=%b oe_n=%b d_out=%h want 0 1 1 %h",
                     reg_req, wait_n, d_oe_n, d_out, exp_dout);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_stray_ack();
        test_random();
        test_back_to_back();
        test_abort();
`ifdef TILE_IO_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_in_done();
        test_reset_in_access();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule : tb_tile_io_responder
`default_nettype wire
